// File: rtl/codebook_fetch.sv
// VRAM read engine that refills the PVR VQ codebook cache, one outstanding burst at a time.
// Define CODEBOOK_FETCH_BURST_EN for BURST_LEN-word requests; otherwise every request is a single word.
module codebook_fetch #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned CB_WORDS  = 256,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cache_wait,
  input  logic [7:0]        ram_read_offset,
  input  logic [ADDR_W-1:0] cb_base_addr,
  output logic              vram_valid,
  output logic [63:0]       cache_din,
  output logic              vram_rd,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_burst_len,
  input  logic              vram_wait,
  input  logic              vram_din_valid,
  input  logic [63:0]       vram_din,
  output logic              fetch_busy,
  output logic              seq_error
);

`ifdef CODEBOOK_FETCH_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  localparam int unsigned EFF_BURST = BURST_EN ? BURST_LEN : 1;
  localparam int unsigned N_BURSTS  = CB_WORDS / EFF_BURST;
  localparam int unsigned WC_W      = $clog2(CB_WORDS) + 1;
  localparam int unsigned BC_W      = $clog2(EFF_BURST) + 1;
  localparam int unsigned BI_W      = $clog2(N_BURSTS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] base_q;
  logic [BI_W-1:0]   burst_idx;
  logic [WC_W-1:0]   word_cnt;
  logic [BC_W-1:0]   beat_cnt;

  logic start;
  logic accept;
  logic last_beat;
  logic last_word;

  assign start     = cache_wait && (ram_read_offset == 8'd0);
  assign accept    = (state_q == REQ) && !vram_wait;
  assign last_beat = (beat_cnt == BC_W'(EFF_BURST - 1));
  assign last_word = ((word_cnt + WC_W'(1)) == WC_W'(CB_WORDS));

  assign vram_rd        = (state_q == REQ);
  assign vram_addr      = base_q + (ADDR_W'(burst_idx) * ADDR_W'(EFF_BURST));
  assign vram_burst_len = 8'(EFF_BURST);
  assign fetch_busy     = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An accepted request is committed at VRAM, so acceptance outranks an abort in REQ;
  // the DATA state then drains that burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = REQ;
      end
      REQ: begin
        if (!vram_wait)       state_d = DATA;
        else if (!cache_wait) state_d = IDLE;
      end
      DATA: begin
        if (vram_din_valid && last_beat) begin
          if (!cache_wait)    state_d = IDLE;
          else if (last_word) state_d = DONE;
          else                state_d = REQ;
        end else if (!cache_wait) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (vram_din_valid && last_beat) state_d = IDLE;
      end
      DONE: begin
        if (!cache_wait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q     <= '0;
      burst_idx  <= '0;
      word_cnt   <= '0;
      beat_cnt   <= '0;
      vram_valid <= 1'b0;
      cache_din  <= '0;
      seq_error  <= 1'b0;
    end else begin
      vram_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q    <= cb_base_addr;
            burst_idx <= '0;
            word_cnt  <= '0;
          end
        end
        REQ: begin
          if (accept) beat_cnt <= '0;
        end
        DATA: begin
          if (vram_din_valid) begin
            vram_valid <= 1'b1;
            cache_din  <= vram_din;
            word_cnt   <= word_cnt + WC_W'(1);
            beat_cnt   <= beat_cnt + BC_W'(1);
            if (ram_read_offset != 8'(word_cnt)) seq_error <= 1'b1;
            if (last_beat) burst_idx <= burst_idx + BI_W'(1);
          end
        end
        DRAIN: begin
          if (vram_din_valid) beat_cnt <= beat_cnt + BC_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_codebook_fetch.sv
// Self-checking bench for codebook_fetch: randomized VRAM stalls against a word-level reference model.
module tb_codebook_fetch;
  localparam int unsigned AW  = 24;
  localparam int unsigned CBW = 256;
`ifdef CODEBOOK_FETCH_BURST_EN
  localparam int unsigned EBL = 8;
`else
  localparam int unsigned EBL = 1;
`endif
  localparam int unsigned NREQ = CBW / EBL;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cache_wait = 1'b0;
  logic [7:0]    ram_read_offset = '0;
  logic [AW-1:0] cb_base_addr = '0;
  logic          vram_wait = 1'b0;
  logic          vram_din_valid = 1'b0;
  logic [63:0]   vram_din = '0;
  logic          vram_valid;
  logic [63:0]   cache_din;
  logic          vram_rd;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_burst_len;
  logic          fetch_busy;
  logic          seq_error;

  codebook_fetch #(.ADDR_W(AW), .CB_WORDS(CBW), .BURST_LEN(8)) dut (
    .clock(clock), .reset(reset), .cache_wait(cache_wait), .ram_read_offset(ram_read_offset),
    .cb_base_addr(cb_base_addr), .vram_valid(vram_valid), .cache_din(cache_din),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_burst_len(vram_burst_len),
    .vram_wait(vram_wait), .vram_din_valid(vram_din_valid), .vram_din(vram_din),
    .fetch_busy(fetch_busy), .seq_error(seq_error)
  );

  always #5 clock = ~clock;

  // VRAM contents: a fixed function of the word address
  function automatic logic [63:0] mem(input logic [AW-1:0] a);
    return {~a, 16'hC0DE, a};
  endfunction

  typedef struct { int unsigned t; logic [AW-1:0] a; } beat_t;
  beat_t         beats[$];
  logic [AW-1:0] req_addr[$];
  logic [7:0]    req_len[$];
  int unsigned   req_cyc[$];
  logic [63:0]   words[$];
  int unsigned   cyc = 0, fwd_cnt = 0, stall_max = 0, stall_left = 0, stab_err = 0, ovl_err = 0;
  bit            auto_off = 1'b1, prev_stalled = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_len = '0;
  int            checks = 0, errors = 0;
  logic          rd_at_start, busy_done, busy_idle;

  // VRAM model (3-cycle latency, random request stalls) plus the cache side of the handshake
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (vram_valid === 1'b1) begin
        words.push_back(cache_din);
        fwd_cnt++;
      end
      if (auto_off) ram_read_offset = 8'(fwd_cnt);
      if (prev_stalled && (vram_rd !== 1'b1 || vram_addr !== prev_addr || vram_burst_len !== prev_len))
        stab_err++;
      if (beats.size() > 0 && beats[0].t <= cyc) begin
        vram_din_valid = 1'b1;
        vram_din = mem(beats[0].a);
        void'(beats.pop_front());
      end else begin
        vram_din_valid = 1'b0;
        vram_din = {$urandom, $urandom};
      end
      if (vram_rd === 1'b1) begin
        if (!prev_stalled) stall_left = $urandom_range(stall_max, 0);
        vram_wait = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        if (!vram_wait) begin
          int unsigned n;
          if (beats.size() > 0) ovl_err++;
          req_addr.push_back(vram_addr);
          req_len.push_back(vram_burst_len);
          req_cyc.push_back(cyc);
          n = int'(vram_burst_len);
          for (int unsigned i = 0; i < n; i++) begin
            beat_t b;
            b.t = cyc + 3 + i;
            b.a = vram_addr + AW'(i);
            beats.push_back(b);
          end
        end
      end else begin
        vram_wait = 1'b0;
      end
      prev_stalled = (vram_rd === 1'b1) && vram_wait;
      prev_addr = vram_addr;
      prev_len = vram_burst_len;
    end
  end

  task automatic clear_logs();
    words.delete(); req_addr.delete(); req_len.delete(); req_cyc.delete();
    fwd_cnt = 0; stab_err = 0; ovl_err = 0;
  endtask

  task automatic do_fetch(input logic [AW-1:0] base, input int unsigned smax);
    stall_max = smax;
    @(negedge clock); #1;
    clear_logs();
    cb_base_addr = base;
    @(negedge clock); #1;
    cache_wait = 1'b1;
    @(negedge clock); #1;
    rd_at_start = vram_rd;
    for (int i = 0; i < 30000 && fwd_cnt < CBW; i++) begin
      @(negedge clock); #1;
    end
    @(negedge clock); #1;
    busy_done = fetch_busy;
    cache_wait = 1'b0;
    @(negedge clock); #1;
    busy_idle = fetch_busy;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    #1;
    checks++; if (vram_rd !== 1'b0) begin errors++; $display("FAIL rst_vram_rd got %0b want 0", vram_rd); end
    checks++; if (vram_valid !== 1'b0) begin errors++; $display("FAIL rst_vram_valid got %0b want 0", vram_valid); end
    checks++; if (cache_din !== 64'd0) begin errors++; $display("FAIL rst_cache_din got %0h want 0", cache_din); end
    checks++; if (vram_addr !== '0) begin errors++; $display("FAIL rst_vram_addr got %0h want 0", vram_addr); end
    checks++; if (vram_burst_len !== 8'(EBL)) begin errors++; $display("FAIL rst_burst_len got %0d want %0d", vram_burst_len, EBL); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rst_fetch_busy got %0b want 0", fetch_busy); end
    checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL rst_seq_error got %0b want 0", seq_error); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [AW-1:0] base = 24'h000100;
    int bad;
    do_fetch(base, 0);
    checks++; if (rd_at_start !== 1'b1) begin errors++; $display("FAIL basic_start_latency vram_rd got %0b want 1", rd_at_start); end
    checks++; if (req_addr.size() != NREQ) begin errors++; $display("FAIL basic_req_count got %0d want %0d", req_addr.size(), NREQ); end
    bad = 0;
    foreach (req_addr[k]) if (req_addr[k] !== base + AW'(k * EBL) || req_len[k] !== 8'(EBL)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_req_addr got %0d bad requests want 0", bad); end
    bad = 0;
    foreach (words[i]) if (words[i] !== mem(base + AW'(i))) bad++;
    checks++; if (words.size() != CBW || bad != 0) begin
      errors++; $display("FAIL basic_words got %0d words (%0d wrong) want %0d words (0 wrong)", words.size(), bad, CBW);
    end
    checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL basic_seq_error got %0b want 0", seq_error); end
    checks++; if (busy_done !== 1'b1) begin errors++; $display("FAIL basic_done_busy got %0b want 1", busy_done); end
    checks++; if (busy_idle !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %0b want 0", busy_idle); end
    checks++; if (ovl_err != 0) begin errors++; $display("FAIL basic_one_outstanding got %0d overlaps want 0", ovl_err); end
  endtask

  task automatic test_stalls();
    for (int r = 0; r < 2; r++) begin
      logic [AW-1:0] base = AW'($urandom);
      int bad = 0;
      do_fetch(base, 5);
      foreach (words[i]) if (words[i] !== mem(base + AW'(i))) bad++;
      checks++; if (words.size() != CBW || bad != 0) begin
        errors++; $display("FAIL stall_words got %0d words (%0d wrong) want %0d words (0 wrong)", words.size(), bad, CBW);
      end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stable got %0d unstable cycles want 0", stab_err); end
      checks++; if (req_addr.size() != NREQ || ovl_err != 0) begin
        errors++; $display("FAIL stall_reqs got %0d reqs %0d overlaps want %0d reqs 0 overlaps", req_addr.size(), ovl_err, NREQ);
      end
    end
    stall_max = 0;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] base = 24'hFFFFF8;
    int bad = 0;
    do_fetch(base, 2);
    foreach (req_addr[k]) if (req_addr[k] !== base + AW'(k * EBL)) bad++;
    checks++; if (req_addr.size() != NREQ || bad != 0) begin
      errors++; $display("FAIL wrap_req_addr got %0d reqs (%0d bad) want %0d reqs (0 bad)", req_addr.size(), bad, NREQ);
    end
    checks++; if (req_addr.size() < 2 || req_addr[1] !== AW'(base + AW'(EBL))) begin
      errors++; $display("FAIL wrap_second_req got %0h want %0h", (req_addr.size() > 1) ? req_addr[1] : '0, AW'(base + AW'(EBL)));
    end
    bad = 0;
    foreach (words[i]) if (words[i] !== mem(base + AW'(i))) bad++;
    checks++; if (words.size() != CBW || bad != 0) begin
      errors++; $display("FAIL wrap_words got %0d words (%0d wrong) want %0d", words.size(), bad, CBW);
    end
    stall_max = 0;
  endtask

  task automatic test_abort();
    logic [AW-1:0] base = AW'($urandom);
    int unsigned drop_cyc, late_reqs, exp_fwd;
    int bad = 0;
    stall_max = 0;
    @(negedge clock); #1;
    clear_logs();
    cb_base_addr = base;
    @(negedge clock); #1;
    cache_wait = 1'b1;
    for (int i = 0; i < 5000 && fwd_cnt < 13; i++) begin
      @(negedge clock); #1;
    end
    drop_cyc = cyc;
    cache_wait = 1'b0;
    repeat (30) @(negedge clock);
    #1;
    // In the burst build word 13 is mid-burst and arrives in the falling cycle, so it is still forwarded
    exp_fwd = (EBL > 1) ? 14 : 13;
    late_reqs = 0;
    foreach (req_cyc[k]) if (req_cyc[k] > drop_cyc) late_reqs++;
    checks++; if (fwd_cnt != exp_fwd) begin errors++; $display("FAIL abort_fwd_count got %0d want %0d", fwd_cnt, exp_fwd); end
    checks++; if (late_reqs != 0) begin errors++; $display("FAIL abort_no_new_rd got %0d reqs want 0", late_reqs); end
    checks++; if (fetch_busy !== 1'b0 || beats.size() != 0) begin
      errors++; $display("FAIL abort_idle busy %0b pending beats %0d want 0 0", fetch_busy, beats.size());
    end
    foreach (words[i]) if (words[i] !== mem(base + AW'(i))) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_words got %0d wrong want 0", bad); end
    base = AW'($urandom);
    do_fetch(base, 1);
    bad = 0;
    foreach (words[i]) if (words[i] !== mem(base + AW'(i))) bad++;
    checks++; if (words.size() != CBW || bad != 0 || seq_error !== 1'b0) begin
      errors++; $display("FAIL abort_refetch got %0d words (%0d wrong) seq_error %0b want %0d 0 0", words.size(), bad, seq_error, CBW);
    end
    stall_max = 0;
  endtask

  task automatic test_reset_mid();
    stall_max = 0;
    @(negedge clock); #1;
    clear_logs();
    cb_base_addr = AW'($urandom);
    @(negedge clock); #1;
    cache_wait = 1'b1;
    for (int i = 0; i < 5000 && fwd_cnt < 3; i++) begin
      @(negedge clock); #1;
    end
    reset = 1'b1;
    cache_wait = 1'b0;
    @(negedge clock); #1;
    checks++; if ({vram_rd, vram_valid, fetch_busy, seq_error} !== 4'b0000) begin
      errors++; $display("FAIL midrst_flags got rd %0b valid %0b busy %0b seqerr %0b want 0 0 0 0", vram_rd, vram_valid, fetch_busy, seq_error);
    end
    checks++; if (cache_din !== 64'd0 || vram_addr !== '0 || vram_burst_len !== 8'(EBL)) begin
      errors++; $display("FAIL midrst_data got din %0h addr %0h len %0d want 0 0 %0d", cache_din, vram_addr, vram_burst_len, EBL);
    end
    reset = 1'b0;
    repeat (12) @(negedge clock);
    #1;
    checks++; if (fwd_cnt != 3 || fetch_busy !== 1'b0) begin
      errors++; $display("FAIL midrst_late_beats got %0d words busy %0b want 3 words busy 0", fwd_cnt, fetch_busy);
    end
  endtask

  task automatic test_seq_error();
    auto_off = 1'b0;
    ram_read_offset = 8'd0;
    @(negedge clock); #1;
    clear_logs();
    cb_base_addr = AW'($urandom);
    cache_wait = 1'b1;
    for (int i = 0; i < 5000 && fwd_cnt < 1; i++) begin
      @(negedge clock); #1;
    end
    checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL seq_word0 got %0b want 0", seq_error); end
    for (int i = 0; i < 5000 && fwd_cnt < 2; i++) begin
      @(negedge clock); #1;
    end
    checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL seq_word1 got %0b want 1", seq_error); end
    cache_wait = 1'b0;
    repeat (30) @(negedge clock);
    #1;
    checks++; if (seq_error !== 1'b1 || fetch_busy !== 1'b0) begin
      errors++; $display("FAIL seq_sticky got seqerr %0b busy %0b want 1 0", seq_error, fetch_busy);
    end
    reset = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0;
    checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL seq_reset_clear got %0b want 0", seq_error); end
    auto_off = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_seq_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/codebook_fetch.md
# codebook_fetch

VRAM read engine that fills the PVR VQ codebook cache on a miss. It watches the cache's `cache_wait` request and fetches the 256 64-bit codebook words from texture VRAM, starting at the latched codebook base address, using one outstanding burst at a time. It returns the words strictly in order as `vram_valid`/`cache_din` pulses, one word per cache `word_index` step. It sits between the codebook cache and the VRAM arbiter port.

## Interface
Parameters:
- `ADDR_W`, 24: VRAM address width in 64-bit-word units.
- `CB_WORDS`, 256: codebook length in words; must be a power of two.
- `BURST_LEN`, 8: words per VRAM burst; must be a power of two dividing `CB_WORDS`.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `cache_wait`  in  1  cache requests codebook words while high.
- `ram_read_offset`  in  8  index of the word the cache expects next.
- `cb_base_addr`  in  ADDR_W  codebook base word address; sampled at fetch start.
- `vram_valid`  out  1  one-cycle strobe: `cache_din` holds the next word.
- `cache_din`  out  64  codebook word to the cache.
- `vram_rd`  out  1  burst read request to VRAM.
- `vram_addr`  out  ADDR_W  burst start address.
- `vram_burst_len`  out  8  words in the requested burst.
- `vram_wait`  in  1  VRAM stall; a request is accepted on a cycle with `vram_rd`=1 and `vram_wait`=0.
- `vram_din_valid`  in  1  VRAM return-data strobe.
- `vram_din`  in  64  VRAM return data.
- `fetch_busy`  out  1  high in every state other than IDLE.
- `seq_error`  out  1  sticky; set when `ram_read_offset` disagrees with the forwarded word count.

## Operation
- States: IDLE, REQ, DATA, DRAIN, DONE.
- IDLE:
  - When `cache_wait`=1 and `ram_read_offset`=0: latch `cb_base_addr` into `base_q`, clear `burst_idx` and `word_cnt`, go to REQ.
  - `vram_din_valid` is ignored in IDLE.
- REQ:
  - `vram_rd`=1; `vram_addr` = `base_q` + `burst_idx`*`BURST_LEN`, modulo 2^ADDR_W, so it wraps at the top of VRAM.
  - `vram_addr` and `vram_burst_len` stay stable while `vram_wait`=1.
  - On acceptance, go to DATA and clear `beat_cnt`.
- DATA:
  - Each `vram_din_valid` increments `beat_cnt` and `word_cnt`, and forwards the data to the cache.
  - After the last beat of the burst, `burst_idx` increments.
  - If `word_cnt` has reached `CB_WORDS`, go to DONE; otherwise go to REQ.
  - Only one burst is outstanding at any time.
- DONE: wait for `cache_wait`=0, then go to IDLE.
- Abort: if `cache_wait` falls in REQ, go to IDLE. This is safe because `vram_rd` has not yet been accepted.
- DRAIN:
  - If `cache_wait` falls in DATA, go to DRAIN.
  - In DRAIN, the remaining beats of the outstanding burst are consumed without forwarding, then the block returns to IDLE.
- Sequence check:
  - On each forwarded word, `seq_error` is set if `ram_read_offset` ≠ `word_cnt[7:0]` (the count before increment).
  - `seq_error` is cleared only by `reset`.
- Counter widths: `word_cnt` is log2(`CB_WORDS`)+1 bits; `beat_cnt` and `burst_idx` are sized to their full ranges without wrap.

## Timing
- Reset values:
  - `vram_rd`=0, `vram_valid`=0, `cache_din`=0, `vram_addr`=0, `vram_burst_len`=`BURST_LEN`, `fetch_busy`=0, `seq_error`=0.
  - State returns to IDLE.
- Reset mid-fetch: immediate return to IDLE. Any late VRAM beats are then ignored as IDLE traffic.
- Start latency: `vram_rd` rises one cycle after the IDLE cycle that sees `cache_wait`=1.
- Data latency: `vram_valid`/`cache_din` are registered and appear one cycle after `vram_din_valid`. `vram_valid` is never high for two words in the same cycle.
- Burst turnaround: next `vram_rd` rises one cycle after the last beat of the previous burst is received.
- `cache_wait` falling in the same cycle as the last beat: that beat is forwarded and the block goes to IDLE, not DONE.
- Back-to-back misses: a new fetch may start one cycle after DONE→IDLE.

## Configuration
- `CODEBOOK_FETCH_BURST_EN` defined:
  - Requests use `BURST_LEN` words.
  - A full codebook takes `CB_WORDS`/`BURST_LEN` requests.
- `CODEBOOK_FETCH_BURST_EN` undefined:
  - Every request is single-word: `vram_burst_len`=1, effective `BURST_LEN`=1.
  - A full codebook takes `CB_WORDS` requests, each followed by REQ→DATA→REQ turnaround.
  - `BURST_LEN` is ignored.

## Test plan
- Basic fetch (burst build), base 0x000100, zero-stall VRAM with 3-cycle read latency:
  - 32 requests at 0x100, 0x108, … 0x1F8.
  - 256 in-order `vram_valid` words equal to VRAM contents.
  - `seq_error`=0; DONE reached.
- Random `vram_wait` stalls of 0-5 cycles: `vram_addr` and `vram_burst_len` stay stable during each stall; exactly 256 words are forwarded.
- Address wrap: base 0xFFFFF8 → requests to 0xFFFFF8, then 0x000000, 0x000008, and so on.
- Abort in DATA: `cache_wait` dropped after word 13:
  - The remaining beats of that burst are drained without `vram_valid`.
  - No new `vram_rd` is issued; the block returns to IDLE.
  - A new fetch then succeeds.
- Synchronous reset asserted mid-burst:
  - All outputs return to their reset values on the next cycle.
  - Late `vram_din_valid` pulses produce no `vram_valid`.
- Non-burst build, and `seq_error` check:
  - Non-burst build: 256 requests with `vram_burst_len`=1.
  - Forcing `ram_read_offset` stuck at 0 sets `seq_error` on word 1, and it stays set until reset.
